mem_stage_unit: RTL and testbench
=================================

Name: mem_stage_unit

Overview:
Consumes the EX/MEM pipeline register outputs and executes the MEM stage. It runs load/store accesses on a req/ack data-memory bus and stalls the pipeline until each access completes. It resolves branch/jump, generating the PC redirect and the if/id/ex flush signals that feed back into the stage registers. It also holds the MEM/WB stage register.

Parameters:
TIMEOUT, 16, cycles in ACCESS without dmem_ack before abort; legal 1..255, 0 disables timeout

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
regwrite_in, memtoreg_in  in  1 each  WB controls from EX/MEM
branch_in, memread_in, memwrite_in, jump_in  in  1 each  MEM controls from EX/MEM
jump_addr_in, branch_addr_in  in  32 each  redirect targets
alu_zero_in  in  1  branch condition
alu_result_in  in  32  memory address / ALU result
reg_read_data_2_in  in  32  store data
ex_mem_registerrd_in  in  5  destination register
dmem_req  out  1  bus request, high throughout ACCESS
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_addr, dmem_wdata  out  32 each  held stable while dmem_req
dmem_ack  in  1  access complete; ignored outside ACCESS
dmem_rdata  in  32  load data, valid with dmem_ack
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
pc_src  out  1  take redirect
pc_target  out  32  redirect address
if_flush, id_flush, ex_flush  out  1 each  flush requests to stage registers
align_err, bus_err  out  1 each  single-cycle error pulses
mem_wb_regwrite, mem_wb_memtoreg  out  1 each  MEM/WB WB controls
mem_wb_read_data, mem_wb_alu_result  out  32 each  MEM/WB data
mem_wb_registerrd  out  5  MEM/WB destination

Behaviour:
- States: IDLE, ACCESS. The 8-bit timeout counter is cleared on entering ACCESS.
- acc = memread_in | memwrite_in. mis = acc & (alu_result_in[1:0] != 0).
- IDLE with acc & ~mis: next state ACCESS. Latch addr, wdata, and we = memwrite_in into dmem_* registers.
  - mem_stall = 1 in this cycle (combinational).
  - If both memread_in and memwrite_in are set, the access is treated as a store.
- IDLE with mis: no request. align_err pulses one cycle later. MEM/WB loads a bubble (regwrite=0). No stall.
- ACCESS, dmem_ack=0: mem_stall=1, counter increments. When counter reaches TIMEOUT-1 (TIMEOUT>0):
  - dmem_req drops next edge and the FSM returns to IDLE.
  - bus_err pulses and MEM/WB loads a bubble.
  - mem_stall is 0 in the abort cycle.
- ACCESS, dmem_ack=1: mem_stall=0, FSM returns to IDLE.
  - MEM/WB loads regwrite_in, memtoreg_in, dmem_rdata, alu_result_in, ex_mem_registerrd_in.
  - Minimum memory op latency: 2 cycles (detect cycle + ack cycle).
- Non-memory instruction, mem_stall=0: MEM/WB loads inputs; mem_wb_read_data loads 0.
- While mem_stall=1: MEM/WB loads a bubble (regwrite=0, memtoreg=0), so WB never repeats.
- Branch resolution (combinational):
  - jump_in=1: pc_src=1, pc_target=jump_addr_in.
  - Else branch_in & alu_zero_in: pc_src=1, pc_target=branch_addr_in.
  - Else pc_src=0, pc_target=0.
  - pc_src and all flushes are gated by ~mem_stall.
  - if_flush = id_flush = ex_flush = pc_src.
  - Jump has priority over branch.
- dmem_we, dmem_addr, and dmem_wdata must not change while dmem_req=1. dmem_req is registered (high exactly when state=ACCESS).
- Reset (sync, any state, including mid-ACCESS):
  - State IDLE, counter 0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - align_err=0, bus_err=0.
  - All mem_wb_* outputs = 0.
  - A dmem_ack arriving in the reset cycle is discarded.
- Combinational outputs (mem_stall, pc_src, pc_target, flushes) are 0 in the reset cycle.

Test Plan:
- Load: memread_in=1, alu_result_in=0x100, regwrite_in=1, rd=5; ack 3 cycles after dmem_req rises with rdata=0xDEADBEEF -> dmem_req high 3 cycles, dmem_we=0, dmem_addr=0x100, mem_stall high 3 cycles then low; mem_wb_read_data=0xDEADBEEF, mem_wb_registerrd=5, mem_wb_regwrite=1 one cycle after ack.
- Store: memwrite_in=1, addr 0x20, data 0x1234; ack on first ACCESS cycle -> dmem_we=1, dmem_wdata=0x1234; stall exactly 1 cycle; MEM/WB bubble during stall.
- Misaligned: memread_in=1, addr 0x102 -> no dmem_req, align_err single pulse, mem_stall=0, mem_wb_regwrite=0.
- Timeout (TIMEOUT=4): load with no ack -> dmem_req high 4 cycles, bus_err pulse, FSM back to IDLE, mem_wb_regwrite=0.
- Redirect: branch_in=1, alu_zero_in=1, branch_addr_in=0x40 -> pc_src=1, pc_target=0x40, all flushes=1. Then jump_in=1 and branch_in=1, jump_addr_in=0x80 -> target 0x80. Then alu_zero_in=0 -> pc_src=0.
- Reset mid-ACCESS after 2 stall cycles, ack concurrent -> next cycle dmem_req=0, mem_wb_*=0, mem_stall=0; a following load starts a fresh access.

Source files
------------

// File: rtl/mem_stage_unit.sv
// MEM pipeline stage: req/ack data-memory access with stall and timeout,
// branch/jump redirect with flush generation, and the MEM/WB stage register.
module mem_stage_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic        jump_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic        alu_zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  ex_mem_registerrd_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_wb_regwrite,
  output logic        mem_wb_memtoreg,
  output logic [31:0] mem_wb_read_data,
  output logic [31:0] mem_wb_alu_result,
  output logic [4:0]  mem_wb_registerrd
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic       TO_EN   = (TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        align_q, align_d;
  logic        bus_q, bus_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic        wb_memtoreg_q, wb_memtoreg_d;
  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  logic acc_s, mis_s, stall_s, redirect_s;
  logic [31:0] target_s;

  // Next-state, bus register and MEM/WB register computation
  always_comb begin
    acc_s           = memread_in | memwrite_in;
    mis_s           = acc_s & (alu_result_in[1:0] != 2'b00);
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    align_d         = 1'b0;
    bus_d           = 1'b0;
    stall_s         = 1'b0;
    // Bubble by default; only a completing instruction writes real values
    wb_regwrite_d   = 1'b0;
    wb_memtoreg_d   = 1'b0;
    wb_read_data_d  = 32'h0000_0000;
    wb_alu_result_d = 32'h0000_0000;
    wb_rd_d         = 5'd0;
    case (state_q)
      S_IDLE: begin
        if (acc_s && !mis_s) begin
          state_d = S_ACCESS;
          cnt_d   = 8'd0;
          addr_d  = alu_result_in;
          wdata_d = reg_read_data_2_in;
          we_d    = memwrite_in;
          stall_s = 1'b1;
        end else if (mis_s) begin
          align_d = 1'b1;
        end else begin
          wb_regwrite_d   = regwrite_in;
          wb_memtoreg_d   = memtoreg_in;
          wb_alu_result_d = alu_result_in;
          wb_rd_d         = ex_mem_registerrd_in;
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          state_d         = S_IDLE;
          wb_regwrite_d   = regwrite_in;
          wb_memtoreg_d   = memtoreg_in;
          wb_read_data_d  = dmem_rdata;
          wb_alu_result_d = alu_result_in;
          wb_rd_d         = ex_mem_registerrd_in;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_IDLE;
          bus_d   = 1'b1;
        end else begin
          stall_s = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_d = (state_d == S_ACCESS);
  end

  // Redirect resolution; jump wins over branch, suppressed while stalled
  always_comb begin
    if (jump_in) begin
      redirect_s = 1'b1;
      target_s   = jump_addr_in;
    end else if (branch_in && alu_zero_in) begin
      redirect_s = 1'b1;
      target_s   = branch_addr_in;
    end else begin
      redirect_s = 1'b0;
      target_s   = 32'h0000_0000;
    end
    mem_stall = stall_s & ~reset;
    if (redirect_s && !stall_s && !reset) begin
      pc_src    = 1'b1;
      pc_target = target_s;
    end else begin
      pc_src    = 1'b0;
      pc_target = 32'h0000_0000;
    end
    if_flush = pc_src;
    id_flush = pc_src;
    ex_flush = pc_src;
  end

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= 32'h0000_0000;
      wdata_q         <= 32'h0000_0000;
      align_q         <= 1'b0;
      bus_q           <= 1'b0;
      wb_regwrite_q   <= 1'b0;
      wb_memtoreg_q   <= 1'b0;
      wb_read_data_q  <= 32'h0000_0000;
      wb_alu_result_q <= 32'h0000_0000;
      wb_rd_q         <= 5'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      req_q           <= req_d;
      we_q            <= we_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      align_q         <= align_d;
      bus_q           <= bus_d;
      wb_regwrite_q   <= wb_regwrite_d;
      wb_memtoreg_q   <= wb_memtoreg_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_rd_q         <= wb_rd_d;
    end
  end

  assign dmem_req          = req_q;
  assign dmem_we           = we_q;
  assign dmem_addr         = addr_q;
  assign dmem_wdata        = wdata_q;
  assign align_err         = align_q;
  assign bus_err           = bus_q;
  assign mem_wb_regwrite   = wb_regwrite_q;
  assign mem_wb_memtoreg   = wb_memtoreg_q;
  assign mem_wb_read_data  = wb_read_data_q;
  assign mem_wb_alu_result = wb_alu_result_q;
  assign mem_wb_registerrd = wb_rd_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit (TIMEOUT=4): load, store, misalign,
// timeout, redirect priority and reset during an access.
module tb_mem_stage_unit;

  logic        clk;
  logic        reset;
  logic        regwrite_in, memtoreg_in, branch_in, memread_in, memwrite_in, jump_in;
  logic [31:0] jump_addr_in, branch_addr_in, alu_result_in, reg_read_data_2_in;
  logic        alu_zero_in;
  logic [4:0]  ex_mem_registerrd_in;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, pc_src, if_flush, id_flush, ex_flush, align_err, bus_err;
  logic [31:0] pc_target;
  logic        mem_wb_regwrite, mem_wb_memtoreg;
  logic [31:0] mem_wb_read_data, mem_wb_alu_result;
  logic [4:0]  mem_wb_registerrd;

  int n_vec = 0;
  int n_err = 0;

  mem_stage_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
    .branch_in(branch_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .jump_in(jump_in), .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .alu_zero_in(alu_zero_in), .alu_result_in(alu_result_in),
    .reg_read_data_2_in(reg_read_data_2_in), .ex_mem_registerrd_in(ex_mem_registerrd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .pc_src(pc_src), .pc_target(pc_target),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .align_err(align_err), .bus_err(bus_err),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_memtoreg(mem_wb_memtoreg),
    .mem_wb_read_data(mem_wb_read_data), .mem_wb_alu_result(mem_wb_alu_result),
    .mem_wb_registerrd(mem_wb_registerrd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    regwrite_in = 1'b0; memtoreg_in = 1'b0; branch_in = 1'b0;
    memread_in = 1'b0; memwrite_in = 1'b0; jump_in = 1'b0;
    jump_addr_in = 32'h0; branch_addr_in = 32'h0; alu_zero_in = 1'b0;
    alu_result_in = 32'h0; reg_read_data_2_in = 32'h0; ex_mem_registerrd_in = 5'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    // Reset state, plus combinational gating during the reset cycle
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wb_rw", {31'h0, mem_wb_regwrite}, 32'h0);
    chk("rst_wb_rd", {27'h0, mem_wb_registerrd}, 32'h0);
    memread_in = 1'b1; alu_result_in = 32'h100; jump_in = 1'b1; jump_addr_in = 32'h80;
    #1;
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_pcsrc", {31'h0, pc_src}, 32'h0);
    clear_inputs();
    tick();
    reset = 1'b0;

    // Load with ack in third ACCESS cycle
    memread_in = 1'b1; alu_result_in = 32'h100; regwrite_in = 1'b1;
    memtoreg_in = 1'b1; ex_mem_registerrd_in = 5'd5;
    #1;
    chk("ld_stall0", {31'h0, mem_stall}, 32'h1);
    chk("ld_req0", {31'h0, dmem_req}, 32'h0);
    tick();
    chk("ld_req1", {31'h0, dmem_req}, 32'h1);
    chk("ld_we", {31'h0, dmem_we}, 32'h0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_bubble", {31'h0, mem_wb_regwrite}, 32'h0);
    chk("ld_stall1", {31'h0, mem_stall}, 32'h1);
    tick();
    chk("ld_req2", {31'h0, dmem_req}, 32'h1);
    chk("ld_stall2", {31'h0, mem_stall}, 32'h1);
    tick();
    chk("ld_req3", {31'h0, dmem_req}, 32'h1);
    chk("ld_addr3", dmem_addr, 32'h100);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld_stall_ack", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("ld_req_off", {31'h0, dmem_req}, 32'h0);
    chk("ld_wb_data", mem_wb_read_data, 32'hDEADBEEF);
    chk("ld_wb_rd", {27'h0, mem_wb_registerrd}, 32'h5);
    chk("ld_wb_rw", {31'h0, mem_wb_regwrite}, 32'h1);
    chk("ld_wb_m2r", {31'h0, mem_wb_memtoreg}, 32'h1);
    chk("ld_wb_alu", mem_wb_alu_result, 32'h100);

    // Non-memory instruction passes straight through
    clear_inputs();
    regwrite_in = 1'b1; ex_mem_registerrd_in = 5'd7; alu_result_in = 32'h55;
    #1;
    chk("nm_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("nm_wb_rw", {31'h0, mem_wb_regwrite}, 32'h1);
    chk("nm_wb_rd", {27'h0, mem_wb_registerrd}, 32'h7);
    chk("nm_wb_data", mem_wb_read_data, 32'h0);
    chk("nm_wb_alu", mem_wb_alu_result, 32'h55);

    // Store acked on first ACCESS cycle
    clear_inputs();
    memwrite_in = 1'b1; alu_result_in = 32'h20; reg_read_data_2_in = 32'h1234;
    regwrite_in = 1'b1; ex_mem_registerrd_in = 5'd9;
    #1;
    chk("st_stall0", {31'h0, mem_stall}, 32'h1);
    tick();
    chk("st_req", {31'h0, dmem_req}, 32'h1);
    chk("st_we", {31'h0, dmem_we}, 32'h1);
    chk("st_wdata", dmem_wdata, 32'h1234);
    chk("st_addr", dmem_addr, 32'h20);
    chk("st_bubble", {31'h0, mem_wb_regwrite}, 32'h0);
    dmem_ack = 1'b1;
    #1;
    chk("st_stall1", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("st_req_off", {31'h0, dmem_req}, 32'h0);
    chk("st_wb_rd", {27'h0, mem_wb_registerrd}, 32'h9);

    // Misaligned load
    clear_inputs();
    memread_in = 1'b1; alu_result_in = 32'h102; regwrite_in = 1'b1; ex_mem_registerrd_in = 5'd4;
    #1;
    chk("mis_stall", {31'h0, mem_stall}, 32'h0);
    tick();
    chk("mis_req", {31'h0, dmem_req}, 32'h0);
    chk("mis_align", {31'h0, align_err}, 32'h1);
    chk("mis_wb_rw", {31'h0, mem_wb_regwrite}, 32'h0);
    clear_inputs();
    tick();
    chk("mis_pulse", {31'h0, align_err}, 32'h0);

    // Timeout: four ACCESS cycles, then abort
    memread_in = 1'b1; alu_result_in = 32'h200; regwrite_in = 1'b1; ex_mem_registerrd_in = 5'd6;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_req", {31'h0, dmem_req}, 32'h1);
      chk("to_stall", {31'h0, mem_stall}, (i == 3) ? 32'h0 : 32'h1);
      chk("to_berr_lo", {31'h0, bus_err}, 32'h0);
    end
    clear_inputs();
    tick();
    chk("to_req_off", {31'h0, dmem_req}, 32'h0);
    chk("to_berr", {31'h0, bus_err}, 32'h1);
    chk("to_wb_rw", {31'h0, mem_wb_regwrite}, 32'h0);
    tick();
    chk("to_berr_pulse", {31'h0, bus_err}, 32'h0);
    chk("to_idle", {31'h0, dmem_req}, 32'h0);

    // Redirects: branch, jump priority, branch not taken
    branch_in = 1'b1; alu_zero_in = 1'b1; branch_addr_in = 32'h40;
    #1;
    chk("br_src", {31'h0, pc_src}, 32'h1);
    chk("br_tgt", pc_target, 32'h40);
    chk("br_flush", {29'h0, if_flush, id_flush, ex_flush}, 32'h7);
    jump_in = 1'b1; jump_addr_in = 32'h80;
    #1;
    chk("jp_tgt", pc_target, 32'h80);
    jump_in = 1'b0; alu_zero_in = 1'b0;
    #1;
    chk("nt_src", {31'h0, pc_src}, 32'h0);
    chk("nt_flush", {29'h0, if_flush, id_flush, ex_flush}, 32'h0);
    clear_inputs();

    // Reset mid-ACCESS with a concurrent ack
    memread_in = 1'b1; alu_result_in = 32'h300; regwrite_in = 1'b1; ex_mem_registerrd_in = 5'd3;
    tick();
    tick();
    chk("ra_req", {31'h0, dmem_req}, 32'h1);
    jump_in = 1'b1; jump_addr_in = 32'h80;
    #1;
    chk("ra_jump_gated", {31'h0, pc_src}, 32'h0);
    jump_in = 1'b0;
    reset = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE;
    #1;
    chk("ra_stall_rst", {31'h0, mem_stall}, 32'h0);
    tick();
    reset = 1'b0; dmem_ack = 1'b0;
    chk("ra_req_off", {31'h0, dmem_req}, 32'h0);
    chk("ra_wb_rw", {31'h0, mem_wb_regwrite}, 32'h0);
    chk("ra_wb_data", mem_wb_read_data, 32'h0);
    chk("ra_wb_rd", {27'h0, mem_wb_registerrd}, 32'h0);
    #1;
    chk("ra_fresh_stall", {31'h0, mem_stall}, 32'h1);
    tick();
    chk("ra_fresh_req", {31'h0, dmem_req}, 32'h1);
    chk("ra_fresh_addr", dmem_addr, 32'h300);
    dmem_ack = 1'b1; dmem_rdata = 32'h11;
    tick();
    chk("ra_fresh_data", mem_wb_read_data, 32'h11);
    chk("ra_fresh_rw", {31'h0, mem_wb_regwrite}, 32'h1);
    clear_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
